// File: rtl/flag_pkg.sv
// Shared definitions for the ALU flag interface: OP encodings, condition codes,
// the {O,C,S,Z} flag struct and the OP-to-update-enable decode.
package flag_pkg;

  localparam int OP_W   = 5;
  localparam int COND_W = 4;

  // Arithmetic group: OP[4:3] == 2'b00
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADC   = 5'b00001;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00010;
  localparam logic [OP_W-1:0] OP_SBB   = 5'b00011;
  localparam logic [OP_W-1:0] OP_INC   = 5'b00100;
  localparam logic [OP_W-1:0] OP_DEC   = 5'b00101;
  localparam logic [OP_W-1:0] OP_NEG   = 5'b00110;
  localparam logic [OP_W-1:0] OP_CMP   = 5'b00111;

  // Shifts
  localparam logic [OP_W-1:0] OP_SHL   = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR   = 5'b01001;

  // 01010..01111 are reserved and never touch the flags
  localparam logic [OP_W-1:0] OP_RSV_LO = 5'b01010;
  localparam logic [OP_W-1:0] OP_RSV_HI = 5'b01111;

  // Logic group
  localparam logic [OP_W-1:0] OP_CLR   = 5'b10000;
  localparam logic [OP_W-1:0] OP_AND   = 5'b10001;
  localparam logic [OP_W-1:0] OP_OR    = 5'b10010;
  localparam logic [OP_W-1:0] OP_PASSB = 5'b10011;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_NAND  = 5'b10101;
  localparam logic [OP_W-1:0] OP_NOR   = 5'b10110;
  localparam logic [OP_W-1:0] OP_XNOR  = 5'b10111;
  localparam logic [OP_W-1:0] OP_ANDN  = 5'b11000;
  localparam logic [OP_W-1:0] OP_ORN   = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOTA  = 5'b11010;
  localparam logic [OP_W-1:0] OP_NOTB  = 5'b11011;
  localparam logic [OP_W-1:0] OP_PASSA = 5'b11100;
  localparam logic [OP_W-1:0] OP_NANDN = 5'b11101;
  localparam logic [OP_W-1:0] OP_NORN  = 5'b11110;
  localparam logic [OP_W-1:0] OP_ONE   = 5'b11111;

  typedef enum logic [COND_W-1:0] {
    COND_ALWAYS = 4'd0,
    COND_EQ     = 4'd1,
    COND_NE     = 4'd2,
    COND_MI     = 4'd3,
    COND_PL     = 4'd4,
    COND_CS     = 4'd5,
    COND_CC     = 4'd6,
    COND_VS     = 4'd7,
    COND_VC     = 4'd8,
    COND_LT     = 4'd9,
    COND_GE     = 4'd10,
    COND_LE     = 4'd11,
    COND_GT     = 4'd12,
    COND_LS     = 4'd13,
    COND_HI     = 4'd14,
    COND_NEVER  = 4'd15
  } cond_e;

  typedef struct packed {
    logic o;
    logic c;
    logic s;
    logic z;
  } flags_t;

  // Mask bit order matches flags_t: {O,C,S,Z}
  function automatic logic [3:0] flag_update_mask(input logic [OP_W-1:0] op);
    logic [3:0] mask;
    mask = 4'b0000;
    if (op[4:3] == 2'b00) begin
      mask = 4'b1111;
    end else if (op == OP_SHL || op == OP_SHR) begin
      mask = 4'b0111;
    end else if (op >= OP_RSV_LO && op <= OP_RSV_HI) begin
      mask = 4'b0000;
    end else if (op == OP_CLR) begin
      mask = 4'b0001;
    end else if (op == OP_PASSB || op == OP_ONE) begin
      mask = 4'b0000;
    end else begin
      mask = 4'b0011;
    end
    return mask;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator; also used by the branch
// predictor checker, so it must stay free of state.
module cond_eval
  import flag_pkg::*;
(
  input  flags_t            flags,
  input  logic [COND_W-1:0] cond,
  output logic              taken
);

  logic lt;

  assign lt = flags.s ^ flags.o;

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = flags.z;
      COND_NE:     taken = ~flags.z;
      COND_MI:     taken = flags.s;
      COND_PL:     taken = ~flags.s;
      COND_CS:     taken = flags.c;
      COND_CC:     taken = ~flags.c;
      COND_VS:     taken = flags.o;
      COND_VC:     taken = ~flags.o;
      COND_LT:     taken = lt;
      COND_GE:     taken = ~lt;
      COND_LE:     taken = flags.z | lt;
      COND_GT:     taken = ~flags.z & ~lt;
      COND_LS:     taken = flags.c | flags.z;
      COND_HI:     taken = ~flags.c & ~flags.z;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register plus one-cycle branch-condition pipeline.
// Optional shadow save/restore is built only when FLAG_SAVE_EN is defined.
module flag_cond_unit
  import flag_pkg::*;
#(
  parameter int OPW = 5,
  parameter int CW  = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           FLAG_WE,
  input  logic [OPW-1:0] OP,
  input  logic           O_IN,
  input  logic           C_IN,
  input  logic           S_IN,
  input  logic           Z_IN,
  input  logic           COND_VALID,
  input  logic [CW-1:0]  COND,
  input  logic           CLR_STICKY,
  input  logic           SAVE,
  input  logic           RESTORE,
  output logic [3:0]     FLAGS,
  output logic           TAKEN_VALID,
  output logic           TAKEN,
  output logic           OVF_STICKY
);

  flags_t     flags_q;
  flags_t     flags_upd;
  flags_t     flags_nxt;
  flags_t     flags_in;
  logic [3:0] upd_mask;
  logic       restore_act;
  logic       sticky_set;
  logic       taken_nxt;

  assign upd_mask = flag_update_mask(OP);
  assign flags_in = '{o: O_IN, c: C_IN, s: S_IN, z: Z_IN};

  always_comb begin
    flags_upd = flags_q;
    if (FLAG_WE) begin
      flags_upd = (flags_q & ~upd_mask) | (flags_in & upd_mask);
    end
  end

`ifdef FLAG_SAVE_EN
  flags_t shadow_q;

  // Restore beats a same-cycle ALU update; SAVE samples pre-edge flags, so
  // SAVE+RESTORE together swaps the two registers.
  assign restore_act = RESTORE;
  assign flags_nxt   = RESTORE ? shadow_q : flags_upd;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_q <= '0;
    end else if (SAVE) begin
      shadow_q <= flags_q;
    end
  end
`else
  logic unused_save_ctl;

  assign unused_save_ctl = SAVE ^ RESTORE;
  assign restore_act     = 1'b0;
  assign flags_nxt       = flags_upd;
`endif

  // An overflow that is overridden by a restore never commits.
  assign sticky_set = FLAG_WE & upd_mask[3] & O_IN & ~restore_act;

  cond_eval u_cond_eval (
    .flags (flags_nxt),
    .cond  (COND),
    .taken (taken_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flags_q     <= '0;
      OVF_STICKY  <= 1'b0;
      TAKEN_VALID <= 1'b0;
      TAKEN       <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      if (sticky_set) begin
        OVF_STICKY <= 1'b1;
      end else if (CLR_STICKY) begin
        OVF_STICKY <= 1'b0;
      end
      TAKEN_VALID <= COND_VALID;
      if (COND_VALID) begin
        TAKEN <= taken_nxt;
      end
    end
  end

  assign FLAGS = flags_q;

endmodule
